// File: rtl/lepes_generator.sv
// ============================================================================
// Module  : lepes_generator
// Brief   : Stepper-motor step pulse generator with trapezoidal ramp profile.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lepes_generator #(
    parameter logic [15:0] KEZDO_PERIODUS = 16'd2000,
    parameter logic [15:0] LEPCSO         = 16'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        irany,
    input  logic [15:0] lepesszam,
    input  logic [15:0] periodus,
    input  logic        megallit,
    output logic        lepes,
    output logic        irany_ki,
    output logic        foglalt,
    output logic        kesz,
    output logic [15:0] pozicio
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GYORSIT = 3'd1;
    localparam logic [2:0] S_HALAD   = 3'd2;
    localparam logic [2:0] S_LASSIT  = 3'd3;
    localparam logic [2:0] S_VEGE    = 3'd4;

    logic [2:0]  r_state;
    logic [15:0] r_timer;
    logic [15:0] r_hatralevo;
    logic [15:0] r_g;
    logic [15:0] r_period;
    logic [15:0] r_target;
    logic [15:0] r_pozicio;
    logic        r_irany;

    logic        w_busy;
    logic        w_step;
    logic [16:0] w_g_plus1;
    logic [15:0] w_h_eff;
    logic [15:0] w_h_next;
    logic [15:0] w_g_dec;
    logic [15:0] w_g_inc;
    logic [16:0] w_up_sum;
    logic [15:0] w_per_up;
    logic [16:0] w_down_lim;
    logic [15:0] w_per_down;
    logic [15:0] w_tgt_min;
    logic [15:0] w_start_tgt;

    assign w_busy = (r_state == S_GYORSIT) || (r_state == S_HALAD) || (r_state == S_LASSIT);
    assign w_step = w_busy && (r_timer == r_period - 16'd1);

    // A stop request caps the remaining steps to what the decel ramp needs;
    // applying it before the step decision makes a coincident step consistent.
    assign w_g_plus1 = {1'b0, r_g} + 17'd1;
    assign w_h_eff   = (megallit && ({1'b0, r_hatralevo} > w_g_plus1)) ? w_g_plus1[15:0] : r_hatralevo;
    assign w_h_next  = w_h_eff - 16'd1;

    assign w_g_dec = (r_g == 16'd0) ? 16'd0 : r_g - 16'd1;
    assign w_g_inc = (r_g == 16'hFFFF) ? r_g : r_g + 16'd1;

    assign w_up_sum   = {1'b0, r_period} + {1'b0, LEPCSO};
    assign w_per_up   = (w_up_sum > {1'b0, KEZDO_PERIODUS}) ? KEZDO_PERIODUS : w_up_sum[15:0];
    assign w_down_lim = {1'b0, r_target} + {1'b0, LEPCSO};
    assign w_per_down = ({1'b0, r_period} > w_down_lim) ? (r_period - LEPCSO) : r_target;

    assign w_tgt_min   = (periodus < KEZDO_PERIODUS) ? periodus : KEZDO_PERIODUS;
    assign w_start_tgt = (w_tgt_min == 16'd0) ? 16'd1 : w_tgt_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= 16'd0;
            r_hatralevo <= 16'd0;
            r_g         <= 16'd0;
            r_period    <= 16'd0;
            r_target    <= 16'd0;
            r_pozicio   <= 16'd0;
            r_irany     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_irany     <= irany;
                        r_hatralevo <= lepesszam;
                        r_period    <= KEZDO_PERIODUS;
                        r_g         <= 16'd0;
                        r_timer     <= 16'd0;
                        r_target    <= w_start_tgt;
                        r_state     <= (lepesszam == 16'd0) ? S_VEGE : S_GYORSIT;
                    end
                end
                S_VEGE: begin
                    r_state <= S_IDLE;
                end
                S_GYORSIT, S_HALAD, S_LASSIT: begin
                    if (w_step) begin
                        r_timer     <= 16'd0;
                        r_pozicio   <= r_irany ? (r_pozicio + 16'd1) : (r_pozicio - 16'd1);
                        r_hatralevo <= w_h_next;
                        if (w_h_next == 16'd0) begin
                            r_state <= S_VEGE;
                        end else if (w_h_next <= r_g) begin
                            r_state  <= S_LASSIT;
                            r_period <= w_per_up;
                            r_g      <= w_g_dec;
                        end else if (r_state == S_GYORSIT) begin
                            r_period <= w_per_down;
                            r_g      <= w_g_inc;
                            if (w_per_down == r_target) begin
                                r_state <= S_HALAD;
                            end
                        end
                    end else begin
                        r_timer     <= r_timer + 16'd1;
                        r_hatralevo <= w_h_eff;
                        if (megallit) begin
                            r_state <= S_LASSIT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lepes    = w_step;
    assign foglalt  = w_busy;
    assign kesz     = (r_state == S_VEGE);
    assign irany_ki = r_irany;
    assign pozicio  = r_pozicio;

endmodule

`default_nettype wire

// File: tb/tb_lepes_generator.sv
// ============================================================================
// Module  : tb_lepes_generator
// Brief   : Self-checking bench for lepes_generator against a step-profile model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lepes_generator;

    localparam int KP = 20;
    localparam int LP = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        irany;
    logic [15:0] lepesszam;
    logic [15:0] periodus;
    logic        megallit;
    logic        lepes;
    logic        irany_ki;
    logic        foglalt;
    logic        kesz;
    logic [15:0] pozicio;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_pos  = 0;
    int lep_q[$];
    int kesz_q[$];
    int exp_q[$];
    logic prev_lepes = 1'b0;

    lepes_generator #(
        .KEZDO_PERIODUS(16'd20),
        .LEPCSO        (16'd5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .irany    (irany),
        .lepesszam(lepesszam),
        .periodus (periodus),
        .megallit (megallit),
        .lepes    (lepes),
        .irany_ki (irany_ki),
        .foglalt  (foglalt),
        .kesz     (kesz),
        .pozicio  (pozicio)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records pulse times and checks lepes is isolated and only seen while busy.
    always @(negedge clk) begin
        if (lepes === 1'b1) begin
            lep_q.push_back(cyc);
            n_checks++;
            if (prev_lepes === 1'b1 || foglalt !== 1'b1) begin
                n_fail++;
                $display("FAIL lepes_protocol: cycle %0d prev_lepes=%0b foglalt=%0b required prev 0 and foglalt 1",
                         cyc, prev_lepes, foglalt);
            end
        end
        if (kesz === 1'b1) kesz_q.push_back(cyc);
        prev_lepes = lepes;
    end

    // Expected absolute lepes cycles for a move; stop applied after step stop_k.
    function automatic void model_move(input int n, input int per, input int stop_k, input int sc);
        int p, g, h, t, tgt;
        bit accel;
        exp_q.delete();
        tgt = (per < KP) ? per : KP;
        if (tgt < 1) tgt = 1;
        p = KP; g = 0; h = n; t = sc; accel = 1'b1;
        for (int i = 1; h > 0; i++) begin
            t = t + p;
            exp_q.push_back(t);
            h = h - 1;
            if (h == 0) break;
            if (h <= g) begin
                accel = 1'b0;
                p = (p + LP > KP) ? KP : p + LP;
                g = (g > 0) ? g - 1 : 0;
            end else if (accel) begin
                p = (p - LP < tgt) ? tgt : p - LP;
                g = g + 1;
                if (p == tgt) accel = 1'b0;
            end
            if (i == stop_k) begin
                if (h > g + 1) h = g + 1;
                accel = 1'b0;
            end
        end
    endfunction

    task automatic run_move(input int n, input int per, input bit dir, input int stop_k, input bit spam,
                            input string name);
        int sc, stop_cyc, kexp;
        bit done;
        @(posedge clk); #1;
        lep_q.delete();
        kesz_q.delete();
        start = 1'b1; lepesszam = 16'(n); periodus = 16'(per); irany = dir;
        sc = cyc;
        model_move(n, per, stop_k, sc);
        stop_cyc = -1;
        done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(posedge clk); #1;
            start = 1'b0; megallit = 1'b0;
            lepesszam = 16'($urandom); periodus = 16'($urandom); irany = 1'($urandom);
            if (kesz_q.size() > 0) begin
                done = 1'b1;
            end else begin
                if (stop_k > 0 && stop_cyc < 0 && lep_q.size() == stop_k)
                    stop_cyc = cyc + int'($urandom_range(0, 4));
                if (cyc == stop_cyc) megallit = 1'b1;
                if (spam && foglalt && $urandom_range(0, 3) == 0) begin
                    start = 1'b1;
                    lepesszam = 16'($urandom_range(1, 200));
                end
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: no kesz within budget, lepes seen %0d required %0d", name, lep_q.size(), exp_q.size());
        end
        n_checks++;
        if (lep_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d lepes, expected %0d", name, lep_q.size(), exp_q.size());
        end
        for (int i = 0; i < lep_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (lep_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_lepes_time[%0d]: got offset %0d expected %0d", name, i, lep_q[i] - sc, exp_q[i] - sc);
            end
        end
        kexp = (exp_q.size() == 0) ? sc + 1 : exp_q[exp_q.size() - 1] + 1;
        n_checks++;
        if (kesz_q.size() !== 1 || kesz_q[0] !== kexp) begin
            n_fail++;
            $display("FAIL %s_kesz: got %0d pulses first at offset %0d expected 1 at offset %0d",
                     name, kesz_q.size(), (kesz_q.size() > 0) ? kesz_q[0] - sc : -1, kexp - sc);
        end
        exp_pos = dir ? exp_pos + exp_q.size() : exp_pos - exp_q.size();
        n_checks++;
        if (pozicio !== 16'(exp_pos)) begin
            n_fail++;
            $display("FAIL %s_pozicio: got %0d expected %0d", name, pozicio, 16'(exp_pos));
        end
        n_checks++;
        if (foglalt !== 1'b0 || kesz !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: foglalt=%0b kesz=%0b expected 0 0", name, foglalt, kesz);
        end
        if (n > 0) begin
            n_checks++;
            if (irany_ki !== dir) begin
                n_fail++;
                $display("FAIL %s_irany_ki: got %0b expected %0b", name, irany_ki, dir);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; irany = 1'b0; megallit = 1'b0;
        lepesszam = 16'd0; periodus = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({lepes, irany_ki, foglalt, kesz, pozicio} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 00000", {lepes, irany_ki, foglalt, kesz, pozicio});
        end
        rst = 1'b0;
        exp_pos = 0;
    endtask

    task automatic test_zero_steps();
        // A stray megallit in IDLE must not disturb anything.
        @(posedge clk); #1; megallit = 1'b1;
        @(posedge clk); #1; megallit = 1'b0;
        n_checks++;
        if (foglalt !== 1'b0 || kesz !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_megallit: foglalt=%0b kesz=%0b expected 0 0", foglalt, kesz);
        end
        run_move(0, 10, 1'b1, 0, 1'b0, "zero_steps");
    endtask

    task automatic test_profile();
        run_move(10, 10, 1'b1, 0, 1'b0, "profile10");
        n_checks++;
        if (pozicio !== 16'd10) begin
            n_fail++;
            $display("FAIL profile10_abs_pos: got %0d expected 10", pozicio);
        end
        run_move(3, 10, 1'b0, 0, 1'b0, "short3");
        n_checks++;
        if (pozicio !== 16'd7) begin
            n_fail++;
            $display("FAIL short3_abs_pos: got %0d expected 7", pozicio);
        end
    endtask

    task automatic test_stop();
        run_move(100, 10, 1'b1, 4, 1'b0, "stop_halad");
        n_checks++;
        if (lep_q.size() !== 7) begin
            n_fail++;
            $display("FAIL stop_halad_total: got %0d steps expected 7", lep_q.size());
        end
    endtask

    task automatic test_back_to_back();
        run_move(12, 8, 1'b0, 0, 1'b1, "busy_start_a");
        run_move(7, 30, 1'b1, 0, 1'b1, "busy_start_b");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int n, per, sk;
            bit dir, sp;
            n   = int'($urandom_range(0, 25));
            per = int'($urandom_range(6, 35));
            dir = 1'($urandom);
            sp  = 1'($urandom);
            sk  = (n > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : 0;
            run_move(n, per, dir, sk, sp, "random");
        end
    endtask

    task automatic test_rst_mid();
        bit seen;
        @(posedge clk); #1;
        lep_q.delete();
        kesz_q.delete();
        start = 1'b1; lepesszam = 16'd50; periodus = 16'd10; irany = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(posedge clk); #1;
            if (lep_q.size() >= 3) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_mid_timeout: got %0d lepes expected 3 before reset", lep_q.size());
        end
        rst = 1'b1; start = 1'b1; megallit = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({lepes, irany_ki, foglalt, kesz, pozicio} !== 20'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected 00000", {lepes, irany_ki, foglalt, kesz, pozicio});
        end
        rst = 1'b0; start = 1'b0; megallit = 1'b0;
        exp_pos = 0;
        lep_q.delete();
        kesz_q.delete();
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (lep_q.size() !== 0 || kesz_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got %0d lepes %0d kesz expected 0 0", lep_q.size(), kesz_q.size());
        end
        run_move(4, 12, 1'b0, 0, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_zero_steps();
        test_profile();
        test_stop();
        test_back_to_back();
        test_random();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
